// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: drives all 8 rows of a 3-input DUT, samples its output and assembles the truth-table code.
// Optional comparison against an expected code is enabled by defining TT_SWEEP_COMPARE_EN.
module tt_sweep_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TT_SWEEP_COMPARE_EN
    input  logic [7:0] expected_code,
    output logic       match,
    output logic [7:0] mismatch_mask,
`endif
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_code
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_row;
    logic [7:0] r_settle;
    logic [7:0] r_shadow;
    logic [7:0] r_code;
    logic [7:0] w_shift;
    assign w_shift = {r_shadow[6:0], dut_out};
    assign tt_code = r_code;
`ifdef TT_SWEEP_COMPARE_EN
    logic       r_match;
    logic [7:0] r_mask;
    assign match         = r_match;
    assign mismatch_mask = r_mask;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next-state: hold each row SETTLE_CYCLES, sample once, stop after row 7
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SETTLE : IDLE;
            SETTLE:  w_next = (r_settle == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            SAMPLE:  w_next = (r_row == 3'd7) ? DONE : SETTLE;
            default: w_next = IDLE;
        endcase
    end
    // outputs: row counter is zero outside a sweep, so it drives the DUT directly
    always_comb begin
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        {in1, in2, in3} = r_row;
    end
    // datapath: row wraps 7->0 on the last sample, so inputs return to 000 in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row    <= '0;
            r_settle <= '0;
            r_shadow <= '0;
            r_code   <= '0;
`ifdef TT_SWEEP_COMPARE_EN
            r_match  <= 1'b0;
            r_mask   <= '0;
`endif
        end else begin
            if (r_state == IDLE && start) begin
                r_row    <= '0;
                r_settle <= '0;
                r_shadow <= '0;
            end
            if (r_state == SETTLE) r_settle <= r_settle + 8'd1;
            if (r_state == SAMPLE) begin
                r_shadow <= w_shift;
                r_row    <= r_row + 3'd1;
                r_settle <= '0;
                if (r_row == 3'd7) begin
                    r_code  <= w_shift;
`ifdef TT_SWEEP_COMPARE_EN
                    r_mask  <= w_shift ^ expected_code;
                    r_match <= (w_shift == expected_code);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: two sweepers (settle 4 and 1) checked every cycle against a timeline model.
module tb_tt_sweep_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] dut_out, in1, in2, in3, busy, done;
    logic [7:0] tt_code [2];
    logic [7:0] fn [2];
    int         mode [2];
    logic       dq [2];
    logic       nz [2];
`ifdef TT_SWEEP_COMPARE_EN
    logic [7:0] ec [2];
    logic       match [2];
    logic [7:0] mask [2];
    logic [7:0] m_mask [2];
    logic       m_match [2];
`endif
    int n_chk = 0, n_pass = 0;
    int ph [2];
    logic [7:0] m_sh [2], m_code [2];
    logic en = 1'b0;
    int pp, ss, er;

    function automatic int sc(input int i);
        return i == 0 ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gi
            logic [2:0] row;
            assign row = {in1[g], in2[g], in3[g]};
            assign dut_out[g] = mode[g] == 1 ? dq[g] : mode[g] == 2 ? nz[g] :
                                mode[g] == 3 ? ~row[0] : fn[g][3'd7 - row];
            always @(posedge clk) begin
                dq[g] <= fn[g][3'd7 - row];
                nz[g] <= 1'($urandom);
            end
            tt_sweep_capture #(.SETTLE_CYCLES(g == 0 ? 4 : 1)) u_dut (
                .clk(clk),
                .rst(rst),
`ifdef TT_SWEEP_COMPARE_EN
                .expected_code(ec[g]),
                .match(match[g]),
                .mismatch_mask(mask[g]),
`endif
                .start(start[g]),
                .dut_out(dut_out[g]),
                .in1(in1[g]),
                .in2(in2[g]),
                .in3(in3[g]),
                .busy(busy[g]),
                .done(done[g]),
                .tt_code(tt_code[g])
            );
        end
    endgenerate

    // ph counts cycles since the accepting edge: rows occupy 1..P, DONE is P+1
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ss = sc(i) + 1;
            pp = 8 * ss;
            if (en) begin
                er = (ph[i] >= 1 && ph[i] <= pp) ? (ph[i] - 1) / ss : 0;
                chk($sformatf("busy%0d", i), busy[i], ph[i] != 0);
                chk($sformatf("done%0d", i), done[i], ph[i] == pp + 1);
                chk($sformatf("row%0d", i), {in1[i], in2[i], in3[i]}, er);
                chk($sformatf("code%0d", i), tt_code[i], m_code[i]);
`ifdef TT_SWEEP_COMPARE_EN
                chk($sformatf("match%0d", i), match[i], m_match[i]);
                chk($sformatf("mask%0d", i), mask[i], m_mask[i]);
`endif
            end
            if (rst) begin
                ph[i] = 0;
                m_sh[i] = 8'h00;
                m_code[i] = 8'h00;
`ifdef TT_SWEEP_COMPARE_EN
                m_mask[i] = 8'h00;
                m_match[i] = 1'b0;
`endif
            end else if (ph[i] == 0) begin
                if (start[i]) begin
                    ph[i] = 1;
                    m_sh[i] = 8'h00;
                end
            end else begin
                if (ph[i] <= pp && ph[i] % ss == 0) m_sh[i] = {m_sh[i][6:0], dut_out[i]};
                if (ph[i] == pp) begin
                    m_code[i] = m_sh[i];
`ifdef TT_SWEEP_COMPARE_EN
                    m_mask[i] = m_sh[i] ^ ec[i];
                    m_match[i] = (m_sh[i] == ec[i]);
`endif
                end
                ph[i] = (ph[i] == pp + 1) ? 0 : ph[i] + 1;
            end
        end
        if (rst) en = 1'b1;
    end

    task automatic sweep(input int i, input logic [7:0] want, input int lat);
        int n;
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 300);
        chk($sformatf("lat%0d", i), n, lat);
        chk($sformatf("result%0d", i), tt_code[i], want);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, nd, d1, d2;
        fn[0] = 8'h8B; fn[1] = 8'h8B;
        mode[0] = 0; mode[1] = 0;
`ifdef TT_SWEEP_COMPARE_EN
        ec[0] = 8'h8B; ec[1] = 8'h8B;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 2'b00);
        chk("rst_code", tt_code[0], 8'h00);
        chk("rst_row", {in1[0], in2[0], in3[0]}, 3'd0);
        @(posedge clk); #1 rst = 1'b0;
        sweep(0, 8'h8B, 41);
        mode[0] = 3; sweep(0, 8'hAA, 41);
        mode[0] = 0; fn[0] = 8'h00; sweep(0, 8'h00, 41);
        fn[0] = 8'hFF; sweep(0, 8'hFF, 41);
        sweep(1, 8'h8B, 17);
        mode[1] = 1; sweep(1, 8'h8B, 17);
        mode[1] = 0;
        // abandon a sweep during row 3
        fn[0] = 8'h8B;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        n = 0;
        while ({in1[0], in2[0], in3[0]} != 3'd3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("row3_seen", {in1[0], in2[0], in3[0]}, 3'd3);
        @(posedge clk); #1 rst = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_row", {in1[0], in2[0], in3[0]}, 3'd0);
        chk("abort_code", tt_code[0], 8'h00);
        nd = 0;
        repeat (45) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        chk("abort_nodone", nd, 0);
        @(posedge clk); #1;
        sweep(0, 8'h8B, 41);
        // start toggled while busy; prior result held until DONE
        mode[0] = 3;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int k = 0; k < 60; k++) begin
            start[0] = (k < 30) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (done[0]) nd++;
            if (k == 20) chk("mid_code", tt_code[0], 8'h8B);
            @(posedge clk); #1;
        end
        chk("one_done", nd, 1);
        chk("second_code", tt_code[0], 8'hAA);
        mode[0] = 0;
        // start held: back-to-back sweeps separated by one IDLE cycle
        start[1] = 1'b1;
        d1 = -1; d2 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done[1]) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        chk("b2b_gap", d2 - d1, 18);
        @(posedge clk); #1 start[1] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
`ifdef TT_SWEEP_COMPARE_EN
        ec[0] = 8'h8B; fn[0] = 8'h8F;
        sweep(0, 8'h8F, 41);
        chk("cmp_match0", match[0], 1'b0);
        chk("cmp_mask04", mask[0], 8'h04);
        fn[0] = 8'h8B;
        sweep(0, 8'h8B, 41);
        chk("cmp_match1", match[0], 1'b1);
        chk("cmp_mask00", mask[0], 8'h00);
        ec[0] = 8'($urandom); ec[1] = 8'($urandom);
`endif
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom % 300) == 0;
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom % 4) == 0;
                if ($urandom % 50 == 0) mode[i] = int'($urandom % 4);
                if ($urandom % 50 == 0) fn[i] = 8'($urandom);
            end
        end
        @(posedge clk); #1 rst = 1'b0; start = 2'b00;
        repeat (50) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
